// File: rtl/acc_taps_pkg.sv
// Shared widths, cfg word layout and context state encoding for the tap accumulator.
package acc_taps_pkg;

  localparam int unsigned PROD_W  = 18;
  localparam int unsigned CFG_W   = 14;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned ACC_W   = 22;

  localparam int unsigned NTAP_W  = 3;
  localparam int unsigned SHIFT_W = 4;
  localparam int unsigned NOUT_W  = 7;

  localparam int unsigned CFG_NTAP_LSB  = 0;
  localparam int unsigned CFG_SHIFT_LSB = CFG_NTAP_LSB + NTAP_W;
  localparam int unsigned CFG_NOUT_LSB  = CFG_SHIFT_LSB + SHIFT_W;

  // cfg word = {nout, shift, ntap}, MSB first
  typedef struct packed {
    logic [NOUT_W-1:0]  nout;
    logic [SHIFT_W-1:0] shift;
    logic [NTAP_W-1:0]  ntap;
  } cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/acc_taps_if.sv
// Multi-flux FIFO handshake bundles: per-lane flags and data, actor side drives read/write.
interface read_interface #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FLUX  = 2
);
  logic [FLUX-1:0]            empty;
  logic [FLUX-1:0]            read;
  logic [FLUX-1:0][WIDTH-1:0] dout;

  modport actor (input empty, input dout, output read);
  modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FLUX  = 2
);
  logic [FLUX-1:0]  full;
  logic             write;
  logic [WIDTH-1:0] din;

  modport actor (input full, output write, output din);
  modport fifo  (output full, input write, input din);
endinterface

// File: rtl/acc_taps_round_sat.sv
// Rounding arithmetic right shift of a signed accumulator value, saturated to the output width.
module round_sat
  import acc_taps_pkg::*;
(
  input  logic signed [ACC_W-1:0]   i_s,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic signed [OUT_W-1:0]   o_result
);

  // One extra bit so the rounding bias cannot overflow at the largest sum
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -EXT_W'(32768);

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_bias;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_r;

  always_comb begin
    w_ext  = {i_s[ACC_W-1], i_s};
    w_bias = '0;
    if (i_shift != '0) begin
      w_bias = EXT_W'(1) << (i_shift - SHIFT_W'(1));
    end
    w_rnd = w_ext + w_bias;
    w_r   = w_rnd >>> i_shift;
    if (w_r > SAT_MAX) begin
      o_result = SAT_MAX[OUT_W-1:0];
    end else if (w_r < SAT_MIN) begin
      o_result = SAT_MIN[OUT_W-1:0];
    end else begin
      o_result = w_r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_taps.sv
// Time-multiplexed multi-flux tap accumulator: sums ntap+1 products per sample, rounds, saturates, writes tagged.
module acc_taps
  import acc_taps_pkg::*;
#(
  parameter int unsigned FLUX = 2
) (
  input logic           clk,
  input logic           rst,
  read_interface.actor  read_port_prod,
  read_interface.actor  read_port_cfg,
  write_interface.actor write_port_sum
);

  localparam int unsigned TAG_W = $clog2(FLUX);

  state_t                    r_state   [FLUX];
  logic signed [ACC_W-1:0]   r_acc     [FLUX];
  logic        [NTAP_W-1:0]  r_cnt_tap [FLUX];
  logic        [NOUT_W-1:0]  r_cnt_out [FLUX];
  logic        [NTAP_W-1:0]  r_ntap    [FLUX];
  logic        [SHIFT_W-1:0] r_shift   [FLUX];
  logic        [NOUT_W-1:0]  r_nout    [FLUX];

  state_t                    w_state_nxt   [FLUX];
  logic signed [ACC_W-1:0]   w_acc_nxt     [FLUX];
  logic        [NTAP_W-1:0]  w_cnt_tap_nxt [FLUX];
  logic        [NOUT_W-1:0]  w_cnt_out_nxt [FLUX];
  logic        [NTAP_W-1:0]  w_ntap_nxt    [FLUX];
  logic        [SHIFT_W-1:0] w_shift_nxt   [FLUX];
  logic        [NOUT_W-1:0]  w_nout_nxt    [FLUX];

  logic [FLUX-1:0]         w_e1;
  logic [FLUX-1:0]         w_e2;
  logic [FLUX-1:0]         w_e3;
  logic                    w_found;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_sel_e1;
  logic                    w_sel_e2;
  logic                    w_sel_e3;
  logic [FLUX-1:0]         w_prod_read;
  logic [FLUX-1:0]         w_cfg_read;
  logic [PROD_W-1:0]       w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_result;
  cfg_t                    w_cfg;

  // Eligibility per flux and lowest-index arbitration; nothing acts while in reset
  always_comb begin
    w_e1    = '0;
    w_e2    = '0;
    w_e3    = '0;
    w_found = 1'b0;
    w_tag   = '0;
    for (int i = 0; i < FLUX; i++) begin
      w_e1[i] = rst && (r_state[i] == IDLE) && !read_port_cfg.empty[i];
      w_e2[i] = rst && (r_state[i] == ACC) && !read_port_prod.empty[i]
                && (r_cnt_tap[i] < r_ntap[i]);
      w_e3[i] = rst && (r_state[i] == ACC) && !read_port_prod.empty[i]
                && (r_cnt_tap[i] == r_ntap[i]) && !write_port_sum.full[i];
      if (!w_found && (w_e1[i] || w_e2[i] || w_e3[i])) begin
        w_found = 1'b1;
        w_tag   = TAG_W'(i);
      end
    end
  end

  assign w_sel_e1 = w_found && w_e1[w_tag];
  assign w_sel_e2 = w_found && w_e2[w_tag];
  assign w_sel_e3 = w_found && w_e3[w_tag];

  // Single shared datapath operating on the selected flux context
  assign w_prod     = read_port_prod.dout[w_tag][PROD_W-1:0];
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sum      = r_acc[w_tag] + w_prod_ext;
  assign w_cfg      = cfg_t'(read_port_cfg.dout[w_tag][CFG_W-1:0]);

  round_sat u_round_sat (
    .i_s      (w_sum),
    .i_shift  (r_shift[w_tag]),
    .o_result (w_result)
  );

  always_comb begin
    w_prod_read = '0;
    w_cfg_read  = '0;
    if (w_sel_e1) begin
      w_cfg_read[w_tag] = 1'b1;
    end
    if (w_sel_e2 || w_sel_e3) begin
      w_prod_read[w_tag] = 1'b1;
    end
  end

  assign read_port_prod.read  = w_prod_read;
  assign read_port_cfg.read   = w_cfg_read;
  assign write_port_sum.write = w_sel_e3;
  assign write_port_sum.din   = w_sel_e3 ? {w_tag, w_result} : 'x;

  // Next-context logic: only the selected flux changes
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_acc_nxt[i]     = r_acc[i];
      w_cnt_tap_nxt[i] = r_cnt_tap[i];
      w_cnt_out_nxt[i] = r_cnt_out[i];
      w_ntap_nxt[i]    = r_ntap[i];
      w_shift_nxt[i]   = r_shift[i];
      w_nout_nxt[i]    = r_nout[i];
    end
    if (w_sel_e1) begin
      w_ntap_nxt[w_tag]    = w_cfg.ntap;
      w_shift_nxt[w_tag]   = w_cfg.shift;
      w_nout_nxt[w_tag]    = w_cfg.nout;
      w_acc_nxt[w_tag]     = '0;
      w_cnt_tap_nxt[w_tag] = '0;
      w_cnt_out_nxt[w_tag] = '0;
      w_state_nxt[w_tag]   = ACC;
    end else if (w_sel_e2) begin
      w_acc_nxt[w_tag]     = w_sum;
      w_cnt_tap_nxt[w_tag] = r_cnt_tap[w_tag] + NTAP_W'(1);
    end else if (w_sel_e3) begin
      w_acc_nxt[w_tag]     = '0;
      w_cnt_tap_nxt[w_tag] = '0;
      if (r_cnt_out[w_tag] == r_nout[w_tag]) begin
        w_state_nxt[w_tag]   = IDLE;
        w_cnt_out_nxt[w_tag] = '0;
      end else begin
        w_cnt_out_nxt[w_tag] = r_cnt_out[w_tag] + NOUT_W'(1);
      end
    end
  end

  // Context registers; reset discards any partial sum
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (!rst) begin
        r_state[i]   <= IDLE;
        r_acc[i]     <= '0;
        r_cnt_tap[i] <= '0;
        r_cnt_out[i] <= '0;
        r_ntap[i]    <= '0;
        r_shift[i]   <= '0;
        r_nout[i]    <= '0;
      end else begin
        r_state[i]   <= w_state_nxt[i];
        r_acc[i]     <= w_acc_nxt[i];
        r_cnt_tap[i] <= w_cnt_tap_nxt[i];
        r_cnt_out[i] <= w_cnt_out_nxt[i];
        r_ntap[i]    <= w_ntap_nxt[i];
        r_shift[i]   <= w_shift_nxt[i];
        r_nout[i]    <= w_nout_nxt[i];
      end
    end
  end

endmodule
